// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver that hands each good byte to the downstream FIFO with a one-cycle rx_irq.
// Define UART_RX_PARITY_EN for 8E1 framing (even parity checked before the stop bit).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
  input logic clock_100M,
  input logic reset,
  input logic rx_serial,
  output logic [7:0] rx_data,
  output logic rx_irq,
  output logic frame_error,
  output logic busy
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t state, state_n;
  logic [1:0] sync;
  logic prev;
  logic [15:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic par_err;
  logic rxs, fell, half_end, bit_end, moving, hold, stop_tick, good;
  assign rxs = sync[1];
  assign fell = prev & ~rxs;
  assign half_end = baud_cnt == 16'(HALF_BIT - 1);
  assign bit_end = baud_cnt == 16'(CLKS_PER_BIT - 1);
  assign moving = state_n != state;
  assign hold = state == IDLE || state == WAIT_IDLE;
  assign stop_tick = state == STOP && bit_end;
  assign good = rxs && !par_err;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = fell ? START : IDLE;
      START: state_n = !half_end ? START : rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA: state_n = bit_end && bit_cnt == 3'd7 ? PARITY : DATA;
      PARITY: state_n = bit_end ? STOP : PARITY;
`else
      DATA: state_n = bit_end && bit_cnt == 3'd7 ? STOP : DATA;
`endif
      // leaving at the stop midpoint lets a back-to-back start edge be caught
      STOP: state_n = !bit_end ? STOP : rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: state_n = rxs ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock_100M) begin
    if (reset) begin
      state <= IDLE;
      sync <= 2'b11;
      prev <= 1'b1;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_irq <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sync <= {sync[0], rx_serial};
      prev <= rxs;
      state <= state_n;
      baud_cnt <= moving || hold || bit_end ? '0 : baud_cnt + 16'd1;
      bit_cnt <= moving ? '0 : bit_cnt + 3'(state == DATA && bit_end);
      if (state == DATA && bit_end) shift[bit_cnt] <= rxs;
      rx_irq <= stop_tick && good;
      frame_error <= stop_tick && !good;
      if (stop_tick && good) rx_data <= shift;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock_100M) begin
    if (reset) par_err <= 1'b0;
    else if (state == PARITY && bit_end) par_err <= ^shift ^ rxs;
  end
`else
  assign par_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- 8N1 UART receiver that sits directly upstream of the 10-entry byte FIFO.
- Deserialises the raw RX pin into bytes.
- For each valid frame, presents the byte on rx_data with a single-cycle rx_irq insertion pulse, which the FIFO consumes.
- Framing faults are flagged and the byte is dropped, never forwarded.

Parameters:
- CLKS_PER_BIT, 10417: clock_100M cycles per bit (100 MHz / 9600 baud, rounded). Legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide): offset from the detected start edge to the start-bit midpoint.

Ports:
- clock_100M  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- rx_serial  input  1  raw asynchronous UART line; idle high
- rx_data  output  8  last correctly received byte, LSB first on the wire
- rx_irq  output  1  one-cycle pulse: rx_data holds a new valid byte
- frame_error  output  1  one-cycle pulse: stop bit sampled low (or parity bad, see Optional Feature)
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-high, sampled on the clock_100M rising edge.
  - Reset values: rx_data=8'h00, rx_irq=0, frame_error=0, busy=0, state=IDLE, both synchronizer flops=1, bit counter=0, baud counter=0.
  - Reset asserted mid-frame aborts the frame immediately. No rx_irq is produced for the partial byte.
- Input path:
  - rx_serial passes through a 2-flop synchronizer. The signal rxs is the second flop's output.
  - A falling edge is detected from a registered copy of rxs (prev=1, rxs=0).
- States:
  - IDLE: wait for a falling edge on rxs, then clear the baud counter and go to START.
  - START: count to HALF_BIT-1. At the midpoint, if rxs=0 go to DATA (bit counter=0, baud counter cleared). If rxs=1 it is a false start: go to IDLE with no outputs.
  - DATA: count to CLKS_PER_BIT-1, then sample rxs into shift register bit [bit counter]. After bit 7 go to STOP (PARITY when the feature is enabled).
  - STOP: count to CLKS_PER_BIT-1, then sample rxs.
    - rxs=1: rx_data <= shift register; rx_irq=1 for exactly the next cycle.
    - rxs=0: frame_error=1 for exactly one cycle; rx_data unchanged. Go to WAIT_IDLE.
    - After a good stop, go to IDLE.
  - WAIT_IDLE: stay until rxs=1 (break/stuck-low line), then go to IDLE. No start is detected while the line is held low.
- Timing, with T0 = the cycle the edge is detected on rxs:
  - Data bit i is sampled at T0+HALF_BIT+(i+1)*CLKS_PER_BIT.
  - Stop is sampled at T0+HALF_BIT+9*CLKS_PER_BIT.
  - rx_irq is high in the following cycle.
- Re-sync: return to IDLE happens at the stop-bit midpoint, so back-to-back frames with no idle gap are received.
- Outputs in the FIFO interface:
  - rx_irq is never high in two consecutive cycles. It is low for at least 9*CLKS_PER_BIT cycles between pulses.
  - rx_data is stable from the pulse until the next good frame.
  - Byte 8'h00 is delivered normally; dropping it is the consumer's concern.
- Counter widths: the baud counter is 16 bits and the bit counter is 3 bits. Neither counter wraps mid-state; each is cleared on every state change.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit CLKS_PER_BIT after data bit 7.
  - Even parity is required: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch the frame still completes through STOP. At stop the byte is dropped, frame_error pulses, and rx_irq does not.
  - Stop is sampled at T0+HALF_BIT+10*CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1 framing as described above, port list unchanged.

Test Plan:
- CLKS_PER_BIT=16, send 8'hA5 (8N1, idle gap 32 cycles):
  - rx_irq pulses exactly once for one cycle, 154±2 cycles after the start edge on rx_serial.
  - rx_data=8'hA5; frame_error stays 0.
- Send 8'h01 then 8'hFE back-to-back with no idle gap: two rx_irq pulses about 160 cycles apart; rx_data 8'h01 then 8'hFE.
- Send 8'h3C with the stop bit forced low:
  - frame_error pulses once; no rx_irq; rx_data keeps its previous value.
  - busy stays 1 until the line returns high.
- Glitch: hold rx_serial low for 4 cycles, then high: no rx_irq, no frame_error, busy returns to 0 within 10 cycles.
- Assert reset for 1 cycle during data bit 4 of 8'h77: all outputs are 0 on the next cycle and no rx_irq. A following 8'h42 frame is received correctly.
- With UART_RX_PARITY_EN: 8'h03 with parity=0 gives rx_irq and rx_data=8'h03. 8'h03 with parity=1 gives frame_error and no rx_irq.
